anubis_inv_round: RTL
=====================

Name: anubis_inv_round

Overview:
- One ANUBIS decryption round. It is the counterpart of the encryption round block and is used by the decryption datapath of the top module.
- Takes a 128-bit ciphertext state and the encryption-schedule round key. It applies the decryption key transform (theta on the key) where required, then steps gamma, tau, theta and sigma over several clocks to allow for ROM lookup settling.
- Uses a start/busy/done handshake. No global counter is needed.

Parameters:
- STAGE_CYCLES, 4: clocks spent in each stage; the result is latched on the last clock. Legal range is 1..15.
- LAST_ROUND, 12: number of the final round. This round skips theta on both the data and the key.

Ports:
- clk  in  1  system clock; all state is updated on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a round; sampled only in IDLE.
- round_number  in  4  0 = initial key addition only; 1..LAST_ROUND = full round.
- cipher_text  in  128  input state; captured on accept.
- round_key  in  128  encryption-schedule key K^(R-r); captured on accept.
- round_plain_text  out  128  round result; held until the next completion.
- busy  out  1  high from the edge after accept until completion.
- done  out  1  one-cycle pulse when round_plain_text updates.
- err  out  1  one-cycle pulse when start arrives with round_number > LAST_ROUND.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE, stage counter = 0.
  - round_plain_text = 0, busy = 0, done = 0, err = 0.
  - Internal data and key registers = 0.
  - After reset release, the next accept proceeds normally.
- States: IDLE, GAMMA, TAU, THETA, SIGMA.
- Accept: on a posedge where state = IDLE, start = 1 and round_number <= LAST_ROUND:
  - Capture cipher_text into data_reg, round_key into key_reg, and round_number.
  - Clear the stage counter. busy goes to 1.
  - Next state is GAMMA if round_number >= 1. If round_number = 0, next state is SIGMA.
- Reject: in IDLE with start = 1 and round_number > LAST_ROUND, err pulses high for one cycle. There is no capture, and state stays IDLE.
- start while busy is ignored. start in the same cycle that done is high is also ignored; the earliest re-accept is the cycle after done.
- Stage timing: the counter runs 0..STAGE_CYCLES-1. On the edge where counter = STAGE_CYCLES-1, the stage result is latched into data_reg, the counter clears, and the state advances.
- GAMMA:
  - data_reg <= gamma(data_reg).
  - In parallel, if 1 <= round_number <= LAST_ROUND-1, key_reg <= theta(key_reg); otherwise key_reg is unchanged.
  - Uses a dedicated key theta instance.
- TAU: data_reg <= tau(data_reg).
- THETA:
  - data_reg <= theta(data_reg).
  - When round_number = LAST_ROUND, data_reg is kept unchanged, but the state still spends STAGE_CYCLES clocks so the latency is uniform.
- SIGMA:
  - round_plain_text <= sigma(key_reg, data_reg), i.e. bitwise XOR.
  - done <= 1 for exactly one cycle, busy <= 0, state <= IDLE.
- Latency, counted from the accept edge to the edge where done rises:
  - 4*STAGE_CYCLES clocks for rounds 1..LAST_ROUND (16 at the default).
  - STAGE_CYCLES clocks for round 0 (4 at the default).
- Inputs may change freely after accept, since only the captured copies are used.
- round_plain_text is stable between done pulses. err and done are never high in the same cycle.
- The counter is 4 bits wide and has no wrap path, because it is cleared at STAGE_CYCLES-1.

Test Plan:
1. Assert reset mid-round, at 7 clocks after accept. Expected: round_plain_text = 0, busy = 0, done = 0 immediately, without waiting for a clock edge. Then start round 3 after release; done arrives exactly 16 clocks after the accept edge.
2. Round 0 with cipher_text = 0 and round_key = 0x0123456789ABCDEF_FEDCBA9876543210. Expected: done after 4 clocks and round_plain_text = round_key. Then round 0 with round_key = 0. Expected: output = cipher_text.
3. Round 5 with random state and key. Expected: output = sigma(theta(K), theta(tau(gamma(X)))) from the gamma/tau/theta/sigma models, and done is high for exactly 1 cycle.
4. Round 12 with random state and key. Expected: output = tau(gamma(X)) XOR K. The key is not transformed and the data skips theta; latency is still 16.
5. start held high continuously with round_number = 2. Expected: accepts separated by 17 clocks, and start during busy is ignored. round_number = 13: err pulses for 1 cycle, busy stays 0, and done never fires.
6. STAGE_CYCLES = 1 build, back-to-back rounds 1..12 chained with output fed to input. Expected: each round takes 4 clocks, and the final state matches a software ANUBIS decryption of a known ciphertext.

Source files
------------

// File: rtl/anubis_inv_round_if.sv
// Start/busy/done bundle for one ANUBIS decryption round: request fields from the
// master, round result and status flags from the slave.
interface anubis_inv_round_if;
  logic         start;
  logic [3:0]   round_number;
  logic [127:0] cipher_text;
  logic [127:0] round_key;
  logic [127:0] round_plain_text;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start, round_number, cipher_text, round_key,
    input  round_plain_text, busy, done, err
  );

  modport slave (
    input  start, round_number, cipher_text, round_key,
    output round_plain_text, busy, done, err
  );
endinterface

// File: rtl/anubis_inv_round.sv
// One ANUBIS decryption round: gamma, tau, theta and sigma are applied as timed stages,
// each held STAGE_CYCLES clocks so the S-box logic has time to settle.
module anubis_inv_round #(
  parameter int STAGE_CYCLES = 4,
  parameter int LAST_ROUND   = 12
) (
  input  logic              clk,
  input  logic              reset,
  anubis_inv_round_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GAMMA, TAU, THETA, SIGMA} state_t;

  localparam logic [3:0]  LAST_CNT = 4'(STAGE_CYCLES - 1);
  localparam logic [3:0]  LAST_RN  = 4'(LAST_ROUND);
  localparam logic [63:0] P_BOX    = 64'h3FE0_54BC_DA96_7821;
  localparam logic [63:0] Q_BOX    = 64'h9E56_A23C_F04D_7B18;

  function automatic logic [3:0] p_box(input logic [3:0] x);
    return P_BOX[{~x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] q_box(input logic [3:0] x);
    return Q_BOX[{~x, 2'b00} +: 4];
  endfunction

  // Involutive S-box built from the P/Q mini-boxes with a middle-bit exchange between layers.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [3:0] u, l;
    u = p_box(x[7:4]);
    l = q_box(x[3:0]);
    {u, l} = {q_box({u[3:2], l[3:2]}), p_box({u[1:0], l[1:0]})};
    return {p_box({u[3:2], l[3:2]}), q_box({u[1:0], l[1:0]})};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
  endfunction

  function automatic logic [7:0] h_mul(input logic [7:0] a, input logic [1:0] h);
    case (h)
      2'd0:    return a;
      2'd1:    return xtime(a);
      2'd2:    return xtime(xtime(a));
      default: return xtime(xtime(a)) ^ xtime(a);
    endcase
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] a);
    logic [127:0] b;
    for (int n = 0; n < 16; n++) b[8*n +: 8] = sbox(a[8*n +: 8]);
    return b;
  endfunction

  // Byte (i,j) of the 4x4 state sits at byte position 4*i+j counted from the MSB.
  function automatic logic [127:0] tau(input logic [127:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        b[8*(15-4*i-j) +: 8] = a[8*(15-4*j-i) +: 8];
    return b;
  endfunction

  // Row vector times had(01,02,04,06) over GF(2^8) mod x^8+x^4+x^3+x^2+1.
  function automatic logic [127:0] theta(input logic [127:0] a);
    logic [127:0] b;
    logic [7:0]   acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc ^= h_mul(a[8*(15-4*i-k) +: 8], 2'(k ^ j));
        b[8*(15-4*i-j) +: 8] = acc;
      end
    return b;
  endfunction

  state_t       state;
  logic [3:0]   cnt;
  logic [3:0]   rn_reg;
  logic [127:0] data_reg, key_reg, result;
  logic         busy_reg, done_reg, err_reg;
  logic [127:0] gamma_out, tau_out, theta_out, key_theta;
  logic         key_xform;

  always_comb begin
    gamma_out = gamma(data_reg);
    tau_out   = tau(data_reg);
    theta_out = theta(data_reg);
    key_theta = theta(key_reg);
    key_xform = (rn_reg != 4'd0) && (rn_reg < LAST_RN);
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; data and key registers are cleared by reset like the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rn_reg   <= '0;
      data_reg <= '0;
      key_reg  <= '0;
      result   <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && (bus.round_number <= LAST_RN)) begin
          data_reg <= bus.cipher_text;
          key_reg  <= bus.round_key;
          rn_reg   <= bus.round_number;
          cnt      <= '0;
          busy_reg <= 1'b1;
          state    <= (bus.round_number == 4'd0) ? SIGMA : GAMMA;
        end else if (bus.start) begin
          err_reg  <= 1'b1;
        end
      end else if (cnt != LAST_CNT) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= '0;
        case (state)
          GAMMA: begin
            data_reg <= gamma_out;
            if (key_xform) key_reg <= key_theta;
            state <= TAU;
          end
          TAU: begin
            data_reg <= tau_out;
            state    <= THETA;
          end
          THETA: begin
            // The final round keeps its data but still spends the full stage time.
            if (rn_reg != LAST_RN) data_reg <= theta_out;
            state <= SIGMA;
          end
          SIGMA: begin
            result   <= key_reg ^ data_reg;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.round_plain_text = result;
  assign bus.busy             = busy_reg;
  assign bus.done             = done_reg;
  assign bus.err              = err_reg;

endmodule
